// File: rtl/mem_exc_unit.sv
// Memory-stage address exception unit: classifies load/store addresses
// against data memory and device windows, raises AdEL/AdES, registers the
// resulting ExcCode for the W stage, records the first faulting address and
// counts address errors.
module mem_exc_unit #(
  parameter int                         ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]          DM_LIMIT   = 32'h0000_1fff,
  parameter int                         NUM_DEV    = 2,
  parameter logic [NUM_DEV*ADDR_W-1:0]  DEV_BASE   = {32'h7f10, 32'h7f00},
  parameter logic [NUM_DEV*ADDR_W-1:0]  DEV_SIZE   = {32'h34, 32'h0c},
  parameter logic [ADDR_W-1:0]          DEV_RO_OFF = 32'h8,
  parameter int                         CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              load,
  input  logic              store,
  input  logic              mfc0,
  input  logic              byte_op,
  input  logic              half_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [6:2]        exc_in,
  input  logic              ack,
  output logic [6:2]        exc_out,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              exc_pending,
  output logic [CNT_W-1:0]  exc_cnt
);

  localparam logic [6:2] EXC_ADEL = 5'd4;
  localparam logic [6:2] EXC_ADES = 5'd5;
  localparam logic [6:2] EXC_OV   = 5'd12;

  logic [NUM_DEV-1:0] dev_hit;
  logic [NUM_DEV-1:0] ro_hit_vec;
  logic               in_dm;
  logic               legal;
  logic               word_op;
  logic               fault;
  logic               load_chk;
  logic               store_chk;
  logic [6:2]         next_code;
  logic               addr_err;
  logic               update;
  logic               capture;

  // Per-device window and read-only register match; the offset form of the
  // window test avoids overflow when a device sits at the top of the map.
  for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
    localparam logic [ADDR_W-1:0] BASE = DEV_BASE[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] SIZE = DEV_SIZE[i*ADDR_W +: ADDR_W];
    assign dev_hit[i]    = (addr >= BASE) && ((addr - BASE) < SIZE);
    assign ro_hit_vec[i] = (addr == BASE + DEV_RO_OFF);
  end

  // Classify the access and pick the next ExcCode; loads outrank stores.
  always_comb begin
    in_dm     = (addr <= DM_LIMIT);
    legal     = in_dm || (|dev_hit);
    word_op   = !byte_op && !half_op;
    fault     = !legal
              || (exc_in == EXC_OV)
              || (half_op && addr[0])
              || ((half_op || byte_op) && !in_dm)
              || (word_op && (addr[1:0] != 2'b00));
    load_chk  = load && !mfc0;
    store_chk = store && !load_chk;
    next_code = exc_in;
    if (load_chk && fault) begin
      next_code = EXC_ADEL;
    end else if (store_chk && (fault || (|ro_hit_vec))) begin
      next_code = EXC_ADES;
    end
    addr_err  = (next_code == EXC_ADEL) || (next_code == EXC_ADES);
    update    = !flush && !stall;
    capture   = update && addr_err && (!exc_pending || ack);
  end

  // W-stage ExcCode register: flush bubbles it, stall holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_out <= '0;
    end else if (flush) begin
      exc_out <= '0;
    end else if (!stall) begin
      exc_out <= next_code;
    end
  end

  // First-error capture of the faulting address; ack frees the slot even
  // while stalled, and a same-edge new error immediately re-fills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_vaddr   <= '0;
      exc_pending <= 1'b0;
    end else if (capture) begin
      bad_vaddr   <= addr;
      exc_pending <= 1'b1;
    end else if (ack) begin
      exc_pending <= 1'b0;
    end
  end

  // Saturating count of every address error that reaches the W stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_cnt <= '0;
    end else if (update && addr_err && (exc_cnt != {CNT_W{1'b1}})) begin
      exc_cnt <= exc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_exc_unit.sv
// Self-checking bench for mem_exc_unit using a reference model and a
// scoreboard of expected exc_out values.
module tb_mem_exc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic        mfc0 = 1'b0;
  logic        byte_op = 1'b0;
  logic        half_op = 1'b0;
  logic [31:0] addr = '0;
  logic [6:2]  exc_in = '0;
  logic        ack = 1'b0;
  logic [6:2]  exc_out;
  logic [31:0] bad_vaddr;
  logic        exc_pending;
  logic [15:0] exc_cnt;

  int tests = 0;
  int fails = 0;

  logic [4:0]  sb[$];
  logic [4:0]  m_out = '0;
  logic [31:0] m_vaddr = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [4:0]  want;

  mem_exc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .load(load), .store(store), .mfc0(mfc0), .byte_op(byte_op),
    .half_op(half_op), .addr(addr), .exc_in(exc_in), .ack(ack),
    .exc_out(exc_out), .bad_vaddr(bad_vaddr), .exc_pending(exc_pending),
    .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  // Reference ExcCode for the default memory map.
  function automatic logic [4:0] model_code(input logic ld, input logic st,
      input logic mf, input logic bo, input logic ho, input logic [31:0] a,
      input logic [4:0] ein);
    logic dm, legal, misal, fault;
    dm    = (a <= 32'h1fff);
    legal = dm || (a >= 32'h7f00 && a <= 32'h7f0b) || (a >= 32'h7f10 && a <= 32'h7f43);
    misal = ho ? a[0] : (bo ? 1'b0 : (a[1:0] != 2'b00));
    fault = !legal || (ein == 5'd12) || misal || ((ho || bo) && !dm);
    if (ld && !mf) return fault ? 5'd4 : ein;
    if (st) return (fault || a == 32'h7f08 || a == 32'h7f18) ? 5'd5 : ein;
    return ein;
  endfunction

  // Drive one M-stage op, advance the model for the coming edge, push the
  // expected exc_out and sample 1 ns after the edge.
  task automatic step(input logic ld, input logic st, input logic mf,
      input logic bo, input logic ho, input logic [31:0] a, input logic [4:0] ein,
      input logic stl, input logic fl, input logic ak);
    logic [4:0] c;
    logic err, upd;
    @(negedge clk);
    load = ld; store = st; mfc0 = mf; byte_op = bo; half_op = ho;
    addr = a; exc_in = ein; stall = stl; flush = fl; ack = ak;
    c   = model_code(ld, st, mf, bo, ho, a, ein);
    err = (c == 5'd4) || (c == 5'd5);
    upd = !fl && !stl;
    if (fl) m_out = '0;
    else if (!stl) m_out = c;
    if (upd && err && (!m_pend || ak)) begin
      m_vaddr = a;
      m_pend  = 1'b1;
    end else if (ak) begin
      m_pend = 1'b0;
    end
    if (upd && err && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    sb.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    load = 0; store = 0; mfc0 = 0; byte_op = 0; half_op = 0;
    addr = '0; exc_in = '0; stall = 0; flush = 0; ack = 0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_out = '0; m_vaddr = '0; m_pend = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (exc_out !== 5'd0) begin fails++; $display("[TB] FAIL reset_exc_out got=%0d want=0", exc_out); end
    tests++; if (bad_vaddr !== 32'd0) begin fails++; $display("[TB] FAIL reset_vaddr got=%h want=0", bad_vaddr); end
    tests++; if (exc_pending !== 1'b0) begin fails++; $display("[TB] FAIL reset_pending got=%b want=0", exc_pending); end
    tests++; if (exc_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_cnt got=%0d want=0", exc_cnt); end
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_load_dm();
    do_reset();
    step(1,0,0,0,0, 32'h1ffc, 5'd0, 0,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd0) begin fails++; $display("[TB] FAIL lw_1ffc got=%0d want=0", exc_out); end
    tests++; if (exc_pending !== 1'b0) begin fails++; $display("[TB] FAIL lw_1ffc_pend got=%b want=0", exc_pending); end
    step(1,0,0,0,0, 32'h1ffe, 5'd0, 0,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd4) begin fails++; $display("[TB] FAIL lw_1ffe got=%0d want=4", exc_out); end
    tests++; if (bad_vaddr !== 32'h1ffe) begin fails++; $display("[TB] FAIL lw_1ffe_vaddr got=%h want=1ffe", bad_vaddr); end
    tests++; if (exc_pending !== 1'b1) begin fails++; $display("[TB] FAIL lw_1ffe_pend got=%b want=1", exc_pending); end
    tests++; if (exc_cnt !== 16'd1) begin fails++; $display("[TB] FAIL lw_1ffe_cnt got=%0d want=1", exc_cnt); end
  endtask

  task automatic test_store_ro();
    do_reset();
    step(0,1,0,0,0, 32'h7f08, 5'd0, 0,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd5) begin fails++; $display("[TB] FAIL sw_7f08 got=%0d want=5", exc_out); end
    step(0,1,0,0,0, 32'h7f18, 5'd0, 0,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd5) begin fails++; $display("[TB] FAIL sw_7f18 got=%0d want=5", exc_out); end
    tests++; if (bad_vaddr !== 32'h7f08) begin fails++; $display("[TB] FAIL first_wins got=%h want=7f08", bad_vaddr); end
    tests++; if (exc_cnt !== 16'd2) begin fails++; $display("[TB] FAIL sw_cnt got=%0d want=2", exc_cnt); end
  endtask

  task automatic test_access_types();
    logic [31:0] a_tab[8]  = '{32'h7f04, 32'h2000, 32'h7f40, 32'h7f0c, 32'h7f40, 32'h1000, 32'h1000, 32'h1ffc};
    logic [4:0]  ld_tab[8] = '{1, 0, 1, 1, 1, 1, 1, 0};
    logic [4:0]  st_tab[8] = '{0, 1, 0, 0, 0, 0, 1, 1};
    logic [4:0]  mf_tab[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic [4:0]  bo_tab[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [4:0]  ho_tab[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    logic [4:0]  ei_tab[8] = '{0, 0, 10, 0, 0, 12, 0, 0};
    logic [4:0]  ex_tab[8] = '{4, 5, 10, 4, 0, 4, 0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(ld_tab[i][0], st_tab[i][0], mf_tab[i][0], bo_tab[i][0], ho_tab[i][0],
           a_tab[i], ei_tab[i], 0,0,1);
      want = sb.pop_front();
      tests++;
      if (exc_out !== want || want !== ex_tab[i]) begin
        fails++;
        $display("[TB] FAIL access_%0d addr=%h got=%0d want=%0d", i, a_tab[i], exc_out, ex_tab[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0,1,0,0,0, 32'h3, 5'd0, 1,0,0);
      want = sb.pop_front();
      tests++; if (exc_out !== want || exc_cnt !== 16'd0 || exc_pending !== 1'b0) begin
        fails++; $display("[TB] FAIL stall_%0d got=%0d/%0d/%b want=0/0/0", i, exc_out, exc_cnt, exc_pending);
      end
    end
    step(0,1,0,0,0, 32'h3, 5'd0, 0,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd5 || exc_cnt !== 16'd1) begin
      fails++; $display("[TB] FAIL unstall got=%0d/%0d want=5/1", exc_out, exc_cnt);
    end
    step(0,1,0,0,0, 32'h3, 5'd0, 1,0,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd5 || exc_cnt !== 16'd1) begin
      fails++; $display("[TB] FAIL stall_hold got=%0d/%0d want=5/1", exc_out, exc_cnt);
    end
    step(0,1,0,0,0, 32'h3, 5'd0, 1,1,0);
    want = sb.pop_front();
    tests++; if (exc_out !== want || want !== 5'd0 || exc_cnt !== 16'd1) begin
      fails++; $display("[TB] FAIL flush got=%0d/%0d want=0/1", exc_out, exc_cnt);
    end
  endtask

  task automatic test_ack();
    do_reset();
    step(1,0,0,0,0, 32'h1ffe, 5'd0, 0,0,0);
    void'(sb.pop_front());
    step(1,0,0,0,1, 32'h1, 5'd0, 0,0,1);
    want = sb.pop_front();
    tests++; if (exc_out !== want || exc_pending !== 1'b1 || bad_vaddr !== 32'h1) begin
      fails++; $display("[TB] FAIL ack_recapture got=%0d/%b/%h want=4/1/1", exc_out, exc_pending, bad_vaddr);
    end
    tests++; if (exc_cnt !== 16'd2) begin fails++; $display("[TB] FAIL ack_cnt got=%0d want=2", exc_cnt); end
    step(0,0,0,0,0, 32'h0, 5'd0, 1,0,1);
    want = sb.pop_front();
    tests++; if (exc_pending !== 1'b0 || exc_out !== want || want !== 5'd4) begin
      fails++; $display("[TB] FAIL ack_in_stall got=%b/%0d want=0/4", exc_pending, exc_out);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65538; i++) begin
      step(1,0,0,0,0, 32'h2, 5'd0, 0,0,0);
      void'(sb.pop_front());
    end
    tests++; if (exc_cnt !== 16'hffff) begin fails++; $display("[TB] FAIL saturate got=%h want=ffff", exc_cnt); end
    tests++; if (exc_cnt !== m_cnt) begin fails++; $display("[TB] FAIL saturate_model got=%h want=%h", exc_cnt, m_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1,0,0,0,0, 32'h1ffe, 5'd0, 1,0,0);
    step(1,0,0,0,0, 32'h1ffe, 5'd0, 0,0,0);
    void'(sb.pop_front());
    want = sb.pop_front();
    tests++; if (exc_pending !== 1'b1 || exc_out !== want) begin
      fails++; $display("[TB] FAIL pre_reset got=%b/%0d want=1/%0d", exc_pending, exc_out, want);
    end
    @(negedge clk);
    stall = 1'b1;
    #1 reset = 1'b1;
    #1;
    tests++; if (exc_out !== 5'd0 || bad_vaddr !== 32'd0 || exc_pending !== 1'b0 || exc_cnt !== 16'd0) begin
      fails++; $display("[TB] FAIL async_reset got=%0d/%h/%b/%0d want=0/0/0/0", exc_out, bad_vaddr, exc_pending, exc_cnt);
    end
    reset = 1'b0;
    stall = 1'b0;
    m_out = '0; m_vaddr = '0; m_pend = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_pool[10] = '{32'h0, 32'h1, 32'h2, 32'h1ffe, 32'h2000,
                                32'h7f08, 32'h7f18, 32'h7f0c, 32'h7f42, 32'h7f44};
    logic [4:0]  e_pool[3]  = '{5'd0, 5'd12, 5'd10};
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0,1), $urandom_range(0,1), ($urandom_range(0,3) == 0),
           $urandom_range(0,1), $urandom_range(0,1), a_pool[$urandom_range(0,9)],
           e_pool[$urandom_range(0,2)], ($urandom_range(0,4) == 0),
           ($urandom_range(0,7) == 0), ($urandom_range(0,3) == 0));
      want = sb.pop_front();
      tests++;
      if (exc_out !== want || bad_vaddr !== m_vaddr || exc_pending !== m_pend || exc_cnt !== m_cnt) begin
        fails++;
        $display("[TB] FAIL b2b_%0d got=%0d/%h/%b/%0d want=%0d/%h/%b/%0d", i,
                 exc_out, bad_vaddr, exc_pending, exc_cnt, want, m_vaddr, m_pend, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_dm();
    test_store_ro();
    test_access_types();
    test_stall_flush();
    test_ack();
    test_async_reset();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_exc_unit.md
MEM_EXC_UNIT -- requirements
Module: mem_exc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DM_LIMIT, default 32'h0000_1fff: highest data-memory byte address; DM spans 0..DM_LIMIT.
REQ-003 SHALL have parameter NUM_DEV, default 2: number of memory-mapped devices.
REQ-004 SHALL have parameter DEV_BASE, default {32'h7f10, 32'h7f00}: packed NUM_DEV×ADDR_W device base addresses; device 0 in the LSBs.
REQ-005 SHALL have parameter DEV_SIZE, default {32'h34, 32'h0c}: packed NUM_DEV×ADDR_W device sizes in bytes.
REQ-006 SHALL have parameter DEV_RO_OFF, default 32'h8: byte offset of the read-only register inside every device.
REQ-007 SHALL have parameter CNT_W, default 16: exception counter width.
REQ-008 SHALL have port clk, input, 1: the single clock.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port stall, input, 1: hold all registers.
REQ-011 SHALL have port flush, input, 1: bubble the output stage.
REQ-012 SHALL have ports load, store, mfc0, byte_op, half_op, each input, 1: M-stage access type.
REQ-013 SHALL have port addr, input, ADDR_W: M-stage effective address.
REQ-014 SHALL have port exc_in, input, [6:2]: upstream ExcCode; 0 = none.
REQ-015 SHALL have port ack, input, 1: CP0 has taken the pending address exception.
REQ-016 SHALL have port exc_out, output, [6:2]: registered ExcCode to W stage.
REQ-017 SHALL have port bad_vaddr, output, ADDR_W: faulting address.
REQ-018 SHALL have port exc_pending, output, 1: captured address error not yet acknowledged.
REQ-019 SHALL have port exc_cnt, output, CNT_W: count of address errors.

Function
REQ-020 in_dm SHALL be addr <= DM_LIMIT; in_dev[i] SHALL be DEV_BASE[i] <= addr <= DEV_BASE[i]+DEV_SIZE[i]-1; legal SHALL be in_dm OR any in_dev.
REQ-021 A load check (load && !mfc0) SHALL produce AdEL (4) when any of the following holds: !legal; exc_in == Ov (12); half_op with addr[0]=1; (half_op or byte_op) with !in_dm; word access with addr[1:0]!=0.
REQ-022 A store check (store && !(load && !mfc0)) SHALL produce AdES (5) under the REQ-021 conditions, or when addr == DEV_BASE[i]+DEV_RO_OFF for any i.
REQ-023 When no check fires, next code SHALL equal exc_in unchanged; load checking SHALL take priority over store checking when both are asserted.
REQ-024 exc_out SHALL present next code one clk edge later (latency 1).
REQ-025 Edge priority SHALL be flush > stall > update: flush sets exc_out=0 and blocks all captures; stall holds every register.
REQ-026 On an unstalled, unflushed edge where next code is AdEL/AdES and exc_pending=0, bad_vaddr SHALL load addr and exc_pending SHALL set.
REQ-027 While exc_pending=1, further errors SHALL NOT overwrite bad_vaddr (first error wins); exc_out still updates.
REQ-028 ack SHALL clear exc_pending at the edge; ack coincident with a new capturable error SHALL leave exc_pending=1 with bad_vaddr = the new addr.
REQ-029 exc_cnt SHALL increment by 1 on every unstalled, unflushed edge whose next code is AdEL/AdES, regardless of exc_pending, and SHALL saturate at all-ones.
REQ-030 ack SHALL be ignored for stall purposes: it acts even when stall=1.

Reset
REQ-031 reset=1 SHALL immediately force exc_out=0, bad_vaddr=0, exc_pending=0, exc_cnt=0, independent of clk; a reset asserted mid-stall or mid-pending SHALL discard all state.

Verification
REQ-032 lw addr=0x1ffc -> exc_out=0; lw addr=0x1ffe -> exc_out=4, bad_vaddr=0x1ffe, exc_pending=1, exc_cnt=1.
REQ-033 sw addr=0x7f08, then sw addr=0x7f18 -> both give exc_out=5; bad_vaddr stays 0x7f08 (first wins); exc_cnt=2.
REQ-034 lb addr=0x7f04 -> 4; sh addr=0x2000 -> 5; lw addr=0x7f40 with mfc0=1 -> exc_out=exc_in.
REQ-035 sw addr=0x3 with stall=1 for 3 cycles -> outputs hold; with flush=1 -> exc_out=0 and exc_cnt unchanged.
REQ-036 ack concurrent with lh addr=0x1 -> exc_pending stays 1, bad_vaddr=0x1; drive 2^CNT_W+2 errors -> exc_cnt=all-ones.
REQ-037 reset pulse between edges while exc_pending=1 -> all outputs 0 before the next clk edge.
